arbitro_round_robin: RTL and testbench

- Transaction-layer arbiter between 4 input FIFOs (show-ahead, head word on data_in_k) and 4 output FIFOs.
- Each cycle it grants at most one input, chosen round-robin among eligible inputs.
- It pops the granted input and, one cycle later, pushes the word into the output FIFO selected by the word's two MSBs.
- Replaces fixed-priority selection so that no input port can starve the others.

---
 rtl/arbitro_round_robin.sv | 120 ++++++++++++
 tb/tb_arbitro_round_robin.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_round_robin.sv
// Round-robin arbiter that moves words from 4 show-ahead input FIFOs to 4 output FIFOs.
// Each word's two MSBs select its destination port. At most one input is granted per cycle.
// The write to the output FIFO follows the pop by one cycle.
module arbitro_round_robin #(
    parameter int FIFO_WORD_SIZE = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [3:0]                empty,
    input  logic [3:0]                almostfull,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_0,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_1,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_2,
    input  logic [FIFO_WORD_SIZE-1:0] data_in_3,
    output logic [3:0]                pop,
    output logic [3:0]                push,
    output logic [FIFO_WORD_SIZE-1:0] data_out_0,
    output logic [FIFO_WORD_SIZE-1:0] data_out_1,
    output logic [FIFO_WORD_SIZE-1:0] data_out_2,
    output logic [FIFO_WORD_SIZE-1:0] data_out_3,
    output logic [1:0]                grant_idx,
    output logic [1:0]                state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_ptr;
    logic [1:0]                r_grant_idx;
    logic [3:0]                r_push;
    logic [FIFO_WORD_SIZE-1:0] r_data_out [4];

    logic [FIFO_WORD_SIZE-1:0] w_data_in [4];
    logic [1:0]                w_dest [4];
    logic [3:0]                w_elig;
    logic                      w_gnt_valid;
    logic [1:0]                w_gnt_idx;
    logic [1:0]                w_cand;
    logic [1:0]                w_gnt_dest;
    logic [FIFO_WORD_SIZE-1:0] w_gnt_data;

    assign w_data_in[0] = data_in_0;
    assign w_data_in[1] = data_in_1;
    assign w_data_in[2] = data_in_2;
    assign w_data_in[3] = data_in_3;

    // Destination decode and per-port eligibility (a blocked head word only blocks its own port)
    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            w_dest[k] = w_data_in[k][FIFO_WORD_SIZE-1 -: 2];
            w_elig[k] = !empty[k] && !almostfull[w_dest[k]];
        end
    end

    // Round-robin scan starting at the pointer; the first eligible port wins
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = r_ptr;
        w_cand      = r_ptr;
        for (int unsigned off = 0; off < 4; off++) begin
            w_cand = r_ptr + 2'(off);
            if (!w_gnt_valid && w_elig[w_cand]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_cand;
            end
        end
    end

    assign w_gnt_dest = w_dest[w_gnt_idx];
    assign w_gnt_data = w_data_in[w_gnt_idx];

    // Combinational pop to the granted input FIFO, suppressed during reset
    always_comb begin
        pop = '0;
        if (!reset && w_gnt_valid) begin
            pop[w_gnt_idx] = 1'b1;
        end
    end

    // FSM plus registered datapath: pointer, grant index, push and output data
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_push      <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                r_data_out[k] <= '0;
            end
        end else begin
            r_push <= '0;
            if (w_gnt_valid) begin
                r_push[w_gnt_dest]     <= 1'b1;
                r_data_out[w_gnt_dest] <= w_gnt_data;
                r_ptr                  <= w_gnt_idx + 2'd1;
                r_grant_idx            <= w_gnt_idx;
                r_state                <= ST_ACTIVE;
            end else if (empty != 4'b1111) begin
                r_state <= ST_STALL;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

    // A word popped just before reset is dropped, so the push it would cause is masked
    // while reset is high instead of leaking out for one cycle.
    assign push       = reset ? 4'b0000 : r_push;
    assign data_out_0 = r_data_out[0];
    assign data_out_1 = r_data_out[1];
    assign data_out_2 = r_data_out[2];
    assign data_out_3 = r_data_out[3];
    assign grant_idx  = r_grant_idx;
    assign state      = r_state;

endmodule

// File: tb/tb_arbitro_round_robin.sv
// Bench for arbitro_round_robin: directed vector table, hand-written corner sequences,
// and randomized traffic compared against a behavioural model.
module tb_arbitro_round_robin;

    localparam int W = 10;

    typedef struct {
        logic         rst;
        logic [3:0]   empty;
        logic [3:0]   af;
        logic [W-1:0] d0;
        logic [3:0]   exp_pop;
        logic [3:0]   exp_push;
        logic [1:0]   exp_state;
    } vec_t;

    logic         clk = 1'b0;
    logic         tb_rst;
    logic [3:0]   tb_empty;
    logic [3:0]   tb_af;
    logic [W-1:0] tb_d [4];
    logic [3:0]   pop;
    logic [3:0]   push;
    logic [W-1:0] data_out_0, data_out_1, data_out_2, data_out_3;
    logic [W-1:0] dut_dout [4];
    logic [1:0]   grant_idx;
    logic [1:0]   state;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what the outputs should be after the most recent clock edge
    int           m_ptr;
    int           m_grant;
    int           m_state;
    logic [3:0]   m_push;
    logic [W-1:0] m_dout [4];

    vec_t tbl [21];

    always #5 clk = ~clk;

    arbitro_round_robin #(.FIFO_WORD_SIZE(W)) dut (
        .clk        (clk),
        .reset      (tb_rst),
        .empty      (tb_empty),
        .almostfull (tb_af),
        .data_in_0  (tb_d[0]),
        .data_in_1  (tb_d[1]),
        .data_in_2  (tb_d[2]),
        .data_in_3  (tb_d[3]),
        .pop        (pop),
        .push       (push),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .data_out_3 (data_out_3),
        .grant_idx  (grant_idx),
        .state      (state)
    );

    assign dut_dout[0] = data_out_0;
    assign dut_dout[1] = data_out_1;
    assign dut_dout[2] = data_out_2;
    assign dut_dout[3] = data_out_3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_grant = 0;
        m_state = 0;
        m_push  = 4'b0000;
        for (int k = 0; k < 4; k++) m_dout[k] = '0;
    endtask

    // One clock cycle: drive at the falling edge, check mid-cycle, then advance the model
    task automatic cycle(input logic rst, input logic [3:0] e, input logic [3:0] af,
                         input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [W-1:0] d3);
        logic [W-1:0] d [4];
        int           sel;
        int           dst;
        logic [3:0]   exp_pop;
        @(negedge clk);
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        tb_rst = rst; tb_empty = e; tb_af = af;
        for (int k = 0; k < 4; k++) tb_d[k] = d[k];
        #1;
        sel = -1;
        for (int off = 0; off < 4; off++) begin
            int k;
            k   = (m_ptr + off) % 4;
            dst = int'(d[k] / (1 << (W - 2)));
            if (sel < 0 && !e[k] && !af[dst]) sel = k;
        end
        exp_pop = (rst || sel < 0) ? 4'b0000 : 4'(1 << sel);
        chk("pop", 32'(pop), 32'(exp_pop));
        chk("push", 32'(push), rst ? 32'd0 : 32'(m_push));
        chk("grant_idx", 32'(grant_idx), 32'(m_grant));
        chk("state", 32'(state), 32'(m_state));
        for (int k = 0; k < 4; k++)
            chk($sformatf("data_out_%0d", k), 32'(dut_dout[k]), 32'(m_dout[k]));
        if (rst) begin
            model_reset();
        end else begin
            m_push = 4'b0000;
            if (sel >= 0) begin
                dst         = int'(d[sel] / (1 << (W - 2)));
                m_push      = 4'(1 << dst);
                m_dout[dst] = d[sel];
                m_ptr       = (sel + 1) % 4;
                m_grant     = sel;
                m_state     = 1;
            end else begin
                m_state = (e != 4'b1111) ? 2 : 0;
            end
        end
    endtask

    initial begin
        logic [W-1:0] da, db, dc, dd;
        da = 10'h0A6; db = 10'h1B7; dc = 10'h217; dd = 10'h345;

        // rst, empty, af, d0, pop, push, state
        tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 10'h0A6, 4'b0000, 4'b0000, 2'd0};
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 10'h0A6, 4'b0000, 4'b0000, 2'd0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0001, 4'b0000, 2'd0};
        tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0010, 4'b0001, 2'd1};
        tbl[4]  = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0100, 4'b0010, 2'd1};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b1000, 4'b0100, 2'd1};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0001, 4'b1000, 2'd1};
        tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0010, 4'b0001, 2'd1};
        tbl[8]  = '{1'b0, 4'b0000, 4'b0010, 10'h0A6, 4'b0100, 4'b0010, 2'd1};
        tbl[9]  = '{1'b0, 4'b0000, 4'b0010, 10'h0A6, 4'b1000, 4'b0100, 2'd1};
        tbl[10] = '{1'b0, 4'b0000, 4'b0010, 10'h0A6, 4'b0001, 4'b1000, 2'd1};
        tbl[11] = '{1'b0, 4'b0000, 4'b0010, 10'h0A6, 4'b0100, 4'b0001, 2'd1};
        tbl[12] = '{1'b0, 4'b0000, 4'b0010, 10'h0A6, 4'b1000, 4'b0100, 2'd1};
        tbl[13] = '{1'b0, 4'b0000, 4'b0010, 10'h0A6, 4'b0001, 4'b1000, 2'd1};
        tbl[14] = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0010, 4'b0001, 2'd1};
        tbl[15] = '{1'b0, 4'b0000, 4'b0000, 10'h0A6, 4'b0100, 4'b0010, 2'd1};
        tbl[16] = '{1'b0, 4'b1110, 4'b0100, 10'h2A6, 4'b0000, 4'b0100, 2'd1};
        tbl[17] = '{1'b0, 4'b1110, 4'b0100, 10'h2A6, 4'b0000, 4'b0000, 2'd2};
        tbl[18] = '{1'b0, 4'b1110, 4'b0000, 10'h2A6, 4'b0001, 4'b0000, 2'd2};
        tbl[19] = '{1'b0, 4'b1111, 4'b0000, 10'h2A6, 4'b0000, 4'b0100, 2'd1};
        tbl[20] = '{1'b0, 4'b1111, 4'b0000, 10'h2A6, 4'b0000, 4'b0000, 2'd0};

        // Bring the DUT out of its unknown power-up state
        tb_rst = 1'b1; tb_empty = 4'b0000; tb_af = 4'b0000;
        tb_d[0] = da; tb_d[1] = db; tb_d[2] = dc; tb_d[3] = dd;
        repeat (2) @(posedge clk);
        model_reset();

        // Directed table: reset, fairness, backpressure skip, stall recovery
        for (int i = 0; i < 21; i++) begin
            cycle(tbl[i].rst, tbl[i].empty, tbl[i].af, tbl[i].d0, db, dc, dd);
            chk($sformatf("tbl%0d_pop", i), 32'(pop), 32'(tbl[i].exp_pop));
            chk($sformatf("tbl%0d_push", i), 32'(push), 32'(tbl[i].exp_push));
            chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
        end
        chk("stall_data_out_2", 32'(data_out_2), 32'h2A6);

        // Drain to idle: ports run empty one at a time, every third cycle
        cycle(1'b1, 4'b0000, 4'b0000, da, db, dc, dd);
        for (int s = 0; s < 15; s++) begin
            int n;
            n = (s / 3 > 4) ? 4 : s / 3;
            cycle(1'b0, 4'((1 << n) - 1), 4'b0000, da, db, dc, dd);
        end
        chk("drain_state_idle", 32'(state), 32'd0);
        chk("drain_push_zero", 32'(push), 32'd0);

        // Reset while a word is in flight
        cycle(1'b1, 4'b0000, 4'b0000, da, db, dc, dd);
        cycle(1'b0, 4'b0000, 4'b0000, da, db, dc, dd);
        cycle(1'b0, 4'b0000, 4'b0000, da, db, dc, dd);
        cycle(1'b0, 4'b0000, 4'b0000, da, db, dc, dd);
        chk("midreset_pop_port2", 32'(pop), 32'b0100);
        cycle(1'b1, 4'b0000, 4'b0000, da, db, dc, dd);
        chk("midreset_push_dropped", 32'(push), 32'd0);
        cycle(1'b0, 4'b0000, 4'b0000, da, db, dc, dd);
        chk("midreset_first_grant", 32'(pop), 32'b0001);
        cycle(1'b0, 4'b0000, 4'b0000, da, db, dc, dd);
        chk("midreset_grant_idx", 32'(grant_idx), 32'd0);
        chk("midreset_push", 32'(push), 32'b0001);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic         r;
            logic [3:0]   e, af;
            r  = ($urandom_range(0, 39) == 0);
            e  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            af = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            cycle(r, e, af, W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)),
                  W'($urandom_range(0, 1023)), W'($urandom_range(0, 1023)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
